zero_check_arbiter: RTL and testbench



---
 rtl/zero_check_arbiter_pkg.sv | 17 +
 rtl/zero_check_arbiter_if.sv | 31 +++
 rtl/zero_check_arbiter_zero_det16.sv | 27 ++
 rtl/zero_check_arbiter.sv | 99 +++++++++
 tb/tb_zero_check_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zero_check_arbiter_pkg.sv
// Shared types and constants for the round-robin zero-check arbiter.
package zero_check_arbiter_pkg;

  localparam int unsigned WIDTH_Z = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zero_check_arbiter_if.sv
// Requester-side bus of the zero-check arbiter: requests, operands, grant and result.
interface zero_check_arbiter_if
  import zero_check_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
);

  localparam int unsigned ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH_Z-1:0] data;
  logic                     clr_cnt;
  logic [N_REQ-1:0]         gnt;
  logic                     result_valid;
  logic                     result_zero;
  logic [ID_W-1:0]          result_id;
  logic [CNT_W-1:0]         zero_cnt;
  logic                     busy;

  modport master (
    output req, data, clr_cnt,
    input  gnt, result_valid, result_zero, result_id, zero_cnt, busy
  );

  modport slave (
    input  req, data, clr_cnt,
    output gnt, result_valid, result_zero, result_id, zero_cnt, busy
  );

endinterface

// File: rtl/zero_check_arbiter_zero_det16.sv
// Shared 16-input zero detector: balanced OR tree followed by one inverter.
module zero_det16
  import zero_check_arbiter_pkg::*;
(
  input  logic [WIDTH_Z-1:0] a,
  output logic               zero_c
);

  logic [7:0] l1_c;
  logic [3:0] l2_c;
  logic [1:0] l3_c;
  logic       any_c;

  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1_c[i] = a[2*i] | a[2*i+1];
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2_c[i] = l1_c[2*i] | l1_c[2*i+1];
  end
  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3_c[i] = l2_c[2*i] | l2_c[2*i+1];
  end

  assign any_c  = l3_c[0] | l3_c[1];
  assign zero_c = ~any_c;

endmodule

// File: rtl/zero_check_arbiter.sv
// Round-robin arbiter sharing one zero detector among N_REQ requesters;
// three cycles per transaction, saturating count of zero results.
module zero_check_arbiter
  import zero_check_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  zero_check_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = id_w(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      id;
  logic [WIDTH_Z-1:0]   operand;
  logic [ID_W-1:0]      winner_c;
  logic [WIDTH_Z-1:0]   winner_data_c;
  logic                 operand_zero_c;

  zero_det16 u_zero_det (
    .a      (operand),
    .zero_c (operand_zero_c)
  );

  // First requester at or after ptr, wrapping; scanning downward lets the nearest one win.
  always_comb begin : rr_select
    logic [ID_W-1:0] idx;
    idx           = '0;
    winner_c      = ptr;
    winner_data_c = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((32'(ptr) + 32'(k)) % N_REQ);
      if (bus.req[idx]) begin
        winner_c      = idx;
        winner_data_c = bus.data[32'(idx) * WIDTH_Z +: WIDTH_Z];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      id               <= '0;
      operand          <= '0;
      bus.gnt          <= '0;
      bus.result_valid <= 1'b0;
      bus.result_zero  <= 1'b0;
      bus.result_id    <= '0;
      bus.zero_cnt     <= '0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            operand  <= winner_data_c;
            id       <= winner_c;
            bus.busy <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          bus.result_zero  <= operand_zero_c;
          bus.result_id    <= id;
          bus.gnt          <= N_REQ'(1) << id;
          bus.result_valid <= 1'b1;
          if (operand_zero_c && (bus.zero_cnt != CNT_MAX)) begin
            bus.zero_cnt <= bus.zero_cnt + 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          bus.gnt          <= '0;
          bus.result_valid <= 1'b0;
          ptr              <= (id == LAST_ID) ? '0 : id + 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          bus.gnt          <= '0;
          bus.result_valid <= 1'b0;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
      endcase
      // A clear in the same cycle as an increment leaves the counter at zero.
      if (bus.clr_cnt) begin
        bus.zero_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_zero_check_arbiter.sv
// Scoreboard bench for zero_check_arbiter: directed cases then random traffic,
// checked against a transaction-level round-robin model.
module tb_zero_check_arbiter;
  import zero_check_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned W  = WIDTH_Z;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zero_check_arbiter_if #(.N_REQ(N), .CNT_W(CW)) bus ();

  zero_check_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct packed { int id; bit zero; int cnt; } exp_t;
  exp_t exp_q[$];
  int   obs_id[$];
  int   obs_t[$];

  // Reference model state
  int m_ptr = 0, m_phase = 0, m_cnt = 0, m_win = 0;
  bit m_zero = 0, m_eval = 0;
  int last_id = 0;
  bit last_zero = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Transaction-level model: pick at sample edge, result one edge later, idle one edge after.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr = 0; m_phase = 0; m_cnt = 0; m_win = 0; m_zero = 0;
      last_id = 0; last_zero = 0;
      exp_q.delete();
    end else begin
      m_eval = 0;
      if (m_phase == 0) begin
        if (bus.req != '0) begin
          for (int k = 0; k < N; k++) begin
            if (bus.req[(m_ptr + k) % N]) begin
              m_win = (m_ptr + k) % N;
              break;
            end
          end
          m_zero  = (bus.data[m_win*W +: W] == '0);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_eval = 1;
        if (m_zero && m_cnt < CNT_MAX) m_cnt++;
        last_id   = m_win;
        last_zero = m_zero;
        m_phase   = 2;
      end else begin
        m_ptr   = (m_win + 1) % N;
        m_phase = 0;
      end
      if (bus.clr_cnt) m_cnt = 0;
      if (m_eval) exp_q.push_back('{id: m_win, zero: m_zero, cnt: m_cnt});
    end
  end

  // Monitor on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_valid", 32'(bus.result_valid), 0);
      check("rst_zero", 32'(bus.result_zero), 0);
      check("rst_id", 32'(bus.result_id), 0);
      check("rst_cnt", 32'(bus.zero_cnt), 0);
      check("rst_busy", 32'(bus.busy), 0);
    end else begin
      check("zero_cnt", 32'(bus.zero_cnt), 32'(m_cnt));
      check("busy", 32'(bus.busy), 32'(m_phase != 0));
      check("valid_timing", 32'(bus.result_valid), 32'(m_phase == 2));
      check("id_hold", 32'(bus.result_id), 32'(last_id));
      check("zero_hold", 32'(bus.result_zero), 32'(last_zero));
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("gnt", 32'(bus.gnt), 32'(1) << e.id);
          check("result_id", 32'(bus.result_id), 32'(e.id));
          check("result_zero", 32'(bus.result_zero), 32'(e.zero));
          check("cnt_at_result", 32'(bus.zero_cnt), 32'(e.cnt));
        end
        obs_id.push_back(int'(bus.result_id));
        obs_t.push_back(cyc_n);
      end else begin
        check("gnt_idle", 32'(bus.gnt), 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bus.data[i*W +: W] = v;
  endtask

  // Present mask; drop each requester when granted unless hold is set.
  task automatic txn(input logic [N-1:0] mask, input int n, input bit hold);
    int got;
    got = 0;
    bus.req = mask;
    for (int c = 0; c < 10 * n && got < n; c++) begin
      @(posedge clk); #1;
      if (bus.gnt != '0) begin
        got++;
        if (!hold) bus.req = bus.req & ~bus.gnt;
      end
    end
    check("grant_count", 32'(got), 32'(n));
    bus.req = '0;
    step(2);
  endtask

  task automatic wait_busy();
    for (int c = 0; c < 10 && !bus.busy; c++) step(1);
    check("busy_seen", 32'(bus.busy), 1);
  endtask

  function automatic logic [W-1:0] rand_word();
    int sel;
    sel = int'($urandom_range(0, 2));
    if (sel == 0) return '0;
    if (sel == 1) return W'(1) << $urandom_range(0, W - 1);
    return W'($urandom);
  endfunction

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.data = '0;
    bus.clr_cnt = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);

    // Reset while a transaction is being evaluated
    set_data(0, '0);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    bus.req = '0;
    step(2);
    reset = 1'b0;
    step(4);
    check("mid_no_grant", 32'(obs_id.size()), 0);
    check("mid_cnt", 32'(bus.zero_cnt), 0);

    // Single requester, zero operand
    set_data(2, '0);
    txn(4'b0100, 1, 0);
    check("single_id", 32'(obs_id[0]), 2);
    check("single_cnt", 32'(bus.zero_cnt), 1);
    check("single_zero", 32'(bus.result_zero), 1);

    // Non-zero operands, including every single-bit pattern
    set_data(0, 16'h8000);
    txn(4'b0001, 1, 0);
    check("nz_zero", 32'(bus.result_zero), 0);
    for (int b = 0; b < 16; b++) begin
      set_data(0, W'(1) << b);
      txn(4'b0001, 1, 0);
      check("sweep_zero", 32'(bus.result_zero), 0);
    end
    check("nz_cnt", 32'(bus.zero_cnt), 1);

    // Continuous round-robin, starting from ptr=0
    for (int i = 0; i < N; i++) set_data(i, 16'h00f0);
    txn(4'b1000, 1, 0);
    obs_id.delete(); obs_t.delete();
    txn(4'b1111, 5, 1);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(obs_id[k]), 32'(k % N));
    for (int k = 0; k < 4; k++) check("rr_spacing", 32'(obs_t[k+1] - obs_t[k]), 3);

    // Wrap from ptr=3
    txn(4'b0100, 1, 0);
    obs_id.delete();
    txn(4'b1001, 2, 0);
    check("wrap_first", 32'(obs_id[0]), 3);
    check("wrap_second", 32'(obs_id[1]), 0);

    // Saturation at 2^CW-1
    set_data(1, '0);
    for (int k = 0; k < 5; k++) txn(4'b0010, 1, 0);
    check("sat_cnt", 32'(bus.zero_cnt), 32'(CNT_MAX));

    // Clear coincident with a zero result
    bus.req = 4'b0010;
    wait_busy();
    bus.clr_cnt = 1'b1;
    step(1);
    bus.clr_cnt = 1'b0;
    bus.req = '0;
    step(3);
    check("clr_wins", 32'(bus.zero_cnt), 0);
    check("clr_zero", 32'(bus.result_zero), 1);

    // Operand change after the sampling edge is ignored
    set_data(0, '0);
    bus.req = 4'b0001;
    wait_busy();
    set_data(0, 16'hffff);
    step(1);
    bus.req = '0;
    step(3);
    check("late_data", 32'(bus.result_zero), 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else set_data(i, rand_word());
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1;
            set_data(i, rand_word());
          end
        end else if ($urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.clr_cnt = ($urandom_range(0, 15) == 0);
      step(1);
    end

    bus.req = '0;
    bus.clr_cnt = 1'b0;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || m_phase != 0); c++) step(1);
    step(2);
    check("drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
